// File: rtl/nonce_scanner.sv
// nonce_scanner: walks a nonce range for one mining job, feeds a fixed-latency
// hasher one nonce per cycle, and reports found / exhausted / aborted.
// Optional build macro: NONCE_SCANNER_CONTINUE_EN -- after a found result is
// accepted, resume scanning the same job at the nonce following the hit.
module nonce_scanner #(
    parameter int HASH_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    // job request
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [31:0]  job_merkle,
    input  logic [31:0]  job_time,
    input  logic [31:0]  job_bits,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    // hasher side
    output logic [255:0] hs_midstate,
    output logic [31:0]  hs_merkle,
    output logic [31:0]  hs_time,
    output logic [31:0]  hs_bits,
    output logic [31:0]  hs_nonce,
    input  logic         hs_found,
    input  logic [255:0] hs_hash,
    // control / result
    input  logic         abort,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [1:0]   res_status,
    output logic [31:0]  res_nonce,
    output logic [255:0] res_hash
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_REPORT
    } state_t;

    localparam logic [1:0] ST_FOUND     = 2'b01;
    localparam logic [1:0] ST_EXHAUSTED = 2'b10;
    localparam logic [1:0] ST_ABORTED   = 2'b11;

    state_t                     r_state;
    logic [255:0]               r_mid;
    logic [31:0]                r_merkle;
    logic [31:0]                r_time;
    logic [31:0]                r_bits;
    logic [31:0]                r_end;
    logic [31:0]                r_cnt;
    logic [31:0]                r_last;
    logic [HASH_LAT-1:0]        r_pipe_vld;
    logic [HASH_LAT-1:0][31:0]  r_pipe_nonce;
    logic [1:0]                 r_res_status;
    logic [31:0]                r_res_nonce;
    logic [255:0]               r_res_hash;

    logic w_active;
    logic w_tail_vld;
    logic w_hit;
    logic w_issue;
    logic w_rest_vld;

    assign w_active   = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign w_tail_vld = r_pipe_vld[HASH_LAT-1];
    // hasher outputs only count when the tail tag marks them as ours
    assign w_hit      = w_active && w_tail_vld && hs_found;
    // abort and a hit both stop issue in the cycle they are seen
    assign w_issue    = (r_state == S_SCAN) && !abort && !w_hit;

    // anything still in flight besides the tail being consumed this cycle
    always_comb begin
        w_rest_vld = 1'b0;
        for (int i = 0; i < HASH_LAT - 1; i++)
            w_rest_vld = w_rest_vld | r_pipe_vld[i];
    end

    assign job_ready   = (r_state == S_IDLE);
    assign busy        = w_active;
    assign res_valid   = (r_state == S_REPORT);
    assign hs_midstate = r_mid;
    assign hs_merkle   = r_merkle;
    assign hs_time     = r_time;
    assign hs_bits     = r_bits;
    assign hs_nonce    = r_cnt;
    assign res_status  = r_res_status;
    assign res_nonce   = r_res_nonce;
    assign res_hash    = r_res_hash;

    // scan control FSM, nonce counter and in-flight tag pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mid        <= '0;
            r_merkle     <= '0;
            r_time       <= '0;
            r_bits       <= '0;
            r_end        <= '0;
            r_cnt        <= '0;
            r_last       <= '0;
            r_pipe_vld   <= '0;
            r_pipe_nonce <= '0;
            r_res_status <= '0;
            r_res_nonce  <= '0;
            r_res_hash   <= '0;
        end else begin
            // tag pipe advances every cycle; a flush below overrides it
            r_pipe_vld[0]   <= w_issue;
            r_pipe_nonce[0] <= r_cnt;
            for (int i = 1; i < HASH_LAT; i++) begin
                r_pipe_vld[i]   <= r_pipe_vld[i-1];
                r_pipe_nonce[i] <= r_pipe_nonce[i-1];
            end
            if (w_issue) begin
                r_cnt  <= r_cnt + 32'd1;
                r_last <= r_cnt;
            end

            case (r_state)
                S_IDLE: begin
                    if (job_valid) begin
                        r_mid    <= job_midstate;
                        r_merkle <= job_merkle;
                        r_time   <= job_time;
                        r_bits   <= job_bits;
                        r_end    <= job_nonce_end;
                        r_cnt    <= job_nonce_start;
                        r_last   <= job_nonce_start - 32'd1;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN, S_DRAIN: begin
                    if (abort) begin
                        r_res_status <= ST_ABORTED;
                        r_res_nonce  <= r_last;
                        r_res_hash   <= '0;
                        r_pipe_vld   <= '0;
                        r_state      <= S_REPORT;
                    end else if (w_hit) begin
                        r_res_status <= ST_FOUND;
                        r_res_nonce  <= r_pipe_nonce[HASH_LAT-1];
                        r_res_hash   <= hs_hash;
                        r_pipe_vld   <= '0;
                        r_state      <= S_REPORT;
                    end else if (r_state == S_SCAN) begin
                        if (r_cnt == r_end)
                            r_state <= S_DRAIN;
                    end else if (!w_rest_vld) begin
                        r_res_status <= ST_EXHAUSTED;
                        r_res_nonce  <= r_end;
                        r_res_hash   <= '0;
                        r_state      <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
`ifdef NONCE_SCANNER_CONTINUE_EN
                        if (r_res_status == ST_FOUND && r_res_nonce != r_end) begin
                            r_cnt   <= r_res_nonce + 32'd1;
                            r_state <= S_SCAN;
                        end else begin
                            r_state <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_scanner.sv
// Bench for nonce_scanner: a stub hasher with a programmable hit list, and a
// reference model that derives the result sequence from the nonce range.
module tb_nonce_scanner;

    localparam int HASH_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [255:0] job_midstate = '0;
    logic [31:0]  job_merkle = '0, job_time = '0, job_bits = '0;
    logic [31:0]  job_nonce_start = '0, job_nonce_end = '0;
    logic [255:0] hs_midstate;
    logic [31:0]  hs_merkle, hs_time, hs_bits, hs_nonce;
    logic         hs_found;
    logic [255:0] hs_hash;
    logic         abort = 1'b0;
    logic         busy;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [1:0]   res_status;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nonce_scanner #(.HASH_LAT(HASH_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_merkle(job_merkle),
        .job_time(job_time), .job_bits(job_bits),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .hs_midstate(hs_midstate), .hs_merkle(hs_merkle), .hs_time(hs_time),
        .hs_bits(hs_bits), .hs_nonce(hs_nonce),
        .hs_found(hs_found), .hs_hash(hs_hash),
        .abort(abort), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_status(res_status), .res_nonce(res_nonce), .res_hash(res_hash)
    );

    // ---------------- stub hasher ----------------
    logic [31:0] finds [4] = '{default: '0};
    int          nfind = 0;
    logic [31:0] hist [HASH_LAT] = '{default: '0};

    function automatic logic [255:0] hash_of(input logic [31:0] n);
        return {n, ~n, n + 32'd1, n ^ 32'hdeadbeef, n, ~n, n + 32'd2, n ^ 32'h12345678};
    endfunction

    function automatic bit in_finds(input logic [31:0] n);
        for (int i = 0; i < nfind; i++)
            if (finds[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        hist[0] <= hs_nonce;
        for (int i = 1; i < HASH_LAT; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        hs_found = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i < nfind && finds[i] == hist[HASH_LAT-1]) hs_found = 1'b1;
        hs_hash = hash_of(hist[HASH_LAT-1]);
    end

    // ---------------- reference model ----------------
    logic [1:0]  exp_st[$];
    logic [31:0] exp_n[$];

    task automatic build_model(input logic [31:0] s, input logic [31:0] e);
        int unsigned len;
        bit          stop;
        bit          any;
        logic [31:0] last;
        logic [31:0] n;
        len  = e - s + 32'd1;
        stop = 1'b0;
        any  = 1'b0;
        last = '0;
        exp_st.delete();
        exp_n.delete();
        for (int unsigned i = 0; i < len && !stop; i++) begin
            n = s + i;
            if (in_finds(n)) begin
                exp_st.push_back(2'b01);
                exp_n.push_back(n);
                any  = 1'b1;
                last = n;
`ifndef NONCE_SCANNER_CONTINUE_EN
                stop = 1'b1;
`endif
            end
        end
`ifdef NONCE_SCANNER_CONTINUE_EN
        if (!any || last != e) begin
`else
        if (!any) begin
`endif
            exp_st.push_back(2'b10);
            exp_n.push_back(e);
        end
    endtask

    // ---------------- job driver ----------------
    logic [255:0] job_mid_q;
    logic [31:0]  job_mrk_q, job_tim_q, job_bit_q;

    task automatic start_job(input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        for (int i = 0; i < 8; i++) job_mid_q[i*32 +: 32] = $urandom;
        job_mrk_q = $urandom;
        job_tim_q = $urandom;
        job_bit_q = $urandom;
        job_midstate    = job_mid_q;
        job_merkle      = job_mrk_q;
        job_time        = job_tim_q;
        job_bits        = job_bit_q;
        job_nonce_start = s;
        job_nonce_end   = e;
        job_valid       = 1'b1;
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_idle: got %b want 1", job_ready);
        end
        @(posedge clk);
        @(negedge clk);
        job_valid    = 1'b0;
        job_midstate = ~job_mid_q;
        job_merkle   = ~job_mrk_q;
        job_time     = ~job_tim_q;
        job_bits     = ~job_bit_q;
        checks++;
        if (busy !== 1'b1 || job_ready !== 1'b0 || hs_midstate !== job_mid_q ||
            hs_merkle !== job_mrk_q || hs_time !== job_tim_q || hs_bits !== job_bit_q) begin
            errors++;
            $display("FAIL job_latch: busy=%b ready=%b merkle=%h want busy=1 ready=0 merkle=%h",
                     busy, job_ready, hs_merkle, job_mrk_q);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({job_ready, busy, res_valid} !== 3'b100 || res_status !== 2'b00 ||
            res_nonce !== 32'd0 || res_hash !== '0 || hs_midstate !== '0 ||
            hs_merkle !== 32'd0 || hs_time !== 32'd0 || hs_bits !== 32'd0 || hs_nonce !== 32'd0) begin
            errors++;
            $display("FAIL reset_vals: rdy/busy/rv=%b%b%b st=%b n=%h want 100 00 00000000",
                     job_ready, busy, res_valid, res_status, res_nonce);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b rv=%b want 1 0", job_ready, res_valid);
        end
    endtask

    // runs one job and compares every reported result with the model
    task automatic test_job(input string tag, input logic [31:0] s, input logic [31:0] e,
                            input int exp_lat, input int hold_max);
        int unsigned  len;
        int           w;
        int           hold;
        bit           stable;
        logic [1:0]   st0;
        logic [31:0]  n0;
        logic [255:0] h0;
        logic [255:0] eh;
        len = e - s + 32'd1;
        build_model(s, e);
        start_job(s, e);
        for (int r = 0; r < exp_st.size(); r++) begin
            w = 0;
            while (res_valid !== 1'b1 && w < 400) begin
                if (r == 0 && w < int'(len)) begin
                    checks++;
                    if (hs_nonce !== s + 32'(w)) begin
                        errors++;
                        $display("FAIL %s issue[%0d]: got %h want %h", tag, w, hs_nonce, s + 32'(w));
                    end
                end
                @(negedge clk);
                w++;
            end
            checks++;
            if (res_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s timeout: result %0d never arrived", tag, r);
                return;
            end
            if (r == 0 && exp_lat >= 0) begin
                checks++;
                if (w != exp_lat) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want %0d", tag, w, exp_lat);
                end
            end
            eh = (exp_st[r] == 2'b01) ? hash_of(exp_n[r]) : '0;
            checks++;
            if (res_status !== exp_st[r] || res_nonce !== exp_n[r] || res_hash !== eh) begin
                errors++;
                $display("FAIL %s result[%0d]: got st=%b n=%h h=%h want st=%b n=%h h=%h",
                         tag, r, res_status, res_nonce, res_hash, exp_st[r], exp_n[r], eh);
            end
            st0 = res_status; n0 = res_nonce; h0 = res_hash;
            hold = $urandom_range(0, hold_max);
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_status !== st0 || res_nonce !== n0 || res_hash !== h0)
                    stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL %s hold[%0d]: result changed before acceptance", tag, r);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            checks++;
            if (r == exp_st.size() - 1) begin
                if (job_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s after_last: ready=%b busy=%b rv=%b want 1 0 0",
                             tag, job_ready, busy, res_valid);
                end
            end else if (job_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s resume: ready=%b busy=%b rv=%b want 0 1 0",
                         tag, job_ready, busy, res_valid);
            end
        end
    endtask

    task automatic test_single();
        nfind = 0;
        test_job("single", 32'h5, 32'h5, HASH_LAT + 1, 2);
    endtask

    task automatic test_wrap();
        nfind = 1;
        finds[0] = 32'h1;
        test_job("wrap", 32'hFFFFFFFE, 32'h2, -1, 2);
    endtask

    task automatic test_untagged();
        // stub also hits on the nonce right after the range end
        nfind = 1;
        finds[0] = 32'd23;
        test_job("untagged", 32'd20, 32'd22, -1, 1);
    endtask

    task automatic test_continue();
        nfind = 2;
        finds[0] = 32'd10;
        finds[1] = 32'd12;
        test_job("cont", 32'd8, 32'd14, -1, 2);
    endtask

    task automatic test_abort();
        logic [1:0]   st0;
        logic [31:0]  n0;
        logic [255:0] h0;
        bit           stable;
        nfind = 0;
        start_job(32'h100, 32'h1FF);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_status !== 2'b11 || res_nonce !== 32'h103 || res_hash !== '0) begin
            errors++;
            $display("FAIL abort_result: rv=%b st=%b n=%h want 1 11 00000103 hash0",
                     res_valid, res_status, res_nonce);
        end
        st0 = res_status; n0 = res_nonce; h0 = res_hash;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) abort = 1'b0;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_status !== st0 || res_nonce !== n0 || res_hash !== h0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL abort_hold: result changed while res_ready low");
        end
        res_ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: ready=%b rv=%b busy=%b want 1 0 0", job_ready, res_valid, busy);
        end
        repeat (2) @(negedge clk);
        abort = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0 || res_status !== 2'b11) begin
            errors++;
            $display("FAIL abort_in_idle: ready=%b rv=%b st=%b want 1 0 11",
                     job_ready, res_valid, res_status);
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        int unsigned len;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) s = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else s = $urandom;
            len = $urandom_range(1, 12);
            nfind = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) finds[k] = s + 32'($urandom_range(0, len + 1));
            test_job("rand", s, s + len - 32'd1, -1, 3);
        end
    endtask

    task automatic test_reset_midscan();
        bit seen;
        nfind = 1;
        finds[0] = 32'h1008;
        start_job(32'h1000, 32'h1100);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({job_ready, busy, res_valid} !== 3'b100 || res_status !== 2'b00 ||
            res_nonce !== 32'd0 || res_hash !== '0 || hs_midstate !== '0 ||
            hs_merkle !== 32'd0 || hs_time !== 32'd0 || hs_bits !== 32'd0 || hs_nonce !== 32'd0) begin
            errors++;
            $display("FAIL midscan_reset_vals: rdy/busy/rv=%b%b%b st=%b nonce=%h hs_nonce=%h want 100 00 0 0",
                     job_ready, busy, res_valid, res_status, res_nonce, hs_nonce);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || job_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midscan_no_result: result or busy seen after reset");
        end
        nfind = 0;
        test_job("post_reset", 32'h40, 32'h42, -1, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_untagged();
        test_abort();
        test_continue();
        test_random();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
